// File: rtl/mem_loader.sv
// mem_loader: serial program/data loader and data-cache port arbiter.
// Receives 12-bit frames ({data[7:0], addr[3:0]}, MSB first) on mosi,
// qualified by csi_n/csd_n, and writes them into the icache or dcache.
// A frame with both selects low reads one dcache byte back on miso.
// While the master holds run_in, the dcache port belongs to the processor.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   csi_n, csd_n, mosi     frame selects and serial data from the master
//   run_in                 run request from the master
//   proc_dwen_in/daddr/wd  processor dcache port request
//   dcache_rdata_in        combinational dcache read data
//   icache_*_out           icache write port
//   dcache_*_out           muxed dcache port
//   miso                   readback serial data
//   proc_en_out            processor enable (PC held in reset when 0)
//   busy_out               frame in progress or commit pending
//   frame_err_out          sticky frame error, cleared only by reset

module mem_loader #(
    parameter int FRAME_W = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       csi_n,
    input  logic       csd_n,
    input  logic       mosi,
    input  logic       run_in,
    input  logic       proc_dwen_in,
    input  logic [3:0] proc_daddr_in,
    input  logic [7:0] proc_dwdata_in,
    input  logic [7:0] dcache_rdata_in,
    output logic       icache_wen_out,
    output logic [3:0] icache_addr_out,
    output logic [7:0] icache_wdata_out,
    output logic       dcache_wen_out,
    output logic [3:0] dcache_addr_out,
    output logic [7:0] dcache_wdata_out,
    output logic       miso,
    output logic       proc_en_out,
    output logic       busy_out,
    output logic       frame_err_out
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        RUN
    } state_t;

    // Frame type encoding is the asserted-select pattern {~csi_n, ~csd_n}.
    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_WD   = 2'b01;
    localparam logic [1:0] T_WI   = 2'b10;
    localparam logic [1:0] T_RD   = 2'b11;

    localparam logic [3:0] CNT_FULL = 4'(FRAME_W);
    localparam logic [3:0] CNT_SAT  = 4'(FRAME_W + 1);
    localparam logic [3:0] CNT_ADDR = 4'd4;

    state_t             state;
    logic [1:0]         ftype;
    logic [3:0]         bitcnt;
    logic [FRAME_W-1:0] shreg;
    logic [7:0]         outreg;
    logic               frame_err;

    // Commit bundle, loaded on the frame-end edge so the write
    // pulse is a clean registered one-cycle strobe.
    logic               cm_iwen;
    logic               cm_dwen;
    logic [3:0]         cm_addr;
    logic [7:0]         cm_data;

    logic [1:0]         sel;
    logic               rd_phase;

    assign sel = {~csi_n, ~csd_n};

    // Read address is stable on the dcache port from edge 4 to frame end.
    assign rd_phase = (state == SHIFT) && (ftype == T_RD)
                   && (bitcnt >= CNT_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ftype     <= T_NONE;
            bitcnt    <= '0;
            shreg     <= '0;
            outreg    <= '0;
            frame_err <= 1'b0;
            cm_iwen   <= 1'b0;
            cm_dwen   <= 1'b0;
            cm_addr   <= '0;
            cm_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    outreg <= '0;
                    if (sel != T_NONE) begin
                        state  <= SHIFT;
                        ftype  <= sel;
                        bitcnt <= 4'd1;
                        shreg  <= {{(FRAME_W-1){1'b0}}, mosi};
                    end else if (run_in) begin
                        state <= RUN;
                    end
                end

                SHIFT: begin
                    if (sel == T_NONE) begin
                        // Frame end.
                        bitcnt <= '0;
                        outreg <= '0;
                        if (bitcnt == CNT_FULL && ftype != T_RD) begin
                            state   <= COMMIT;
                            cm_iwen <= (ftype == T_WI);
                            cm_dwen <= (ftype == T_WD);
                            cm_addr <= shreg[3:0];
                            cm_data <= shreg[FRAME_W-1 -: 8];
                        end else begin
                            state <= IDLE;
                            if (bitcnt != CNT_FULL) begin
                                frame_err <= 1'b1;
                            end
                        end
                    end else if (sel != ftype) begin
                        // Select pattern switched to another type.
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        bitcnt    <= '0;
                        outreg    <= '0;
                    end else begin
                        if (bitcnt != CNT_SAT) begin
                            bitcnt <= bitcnt + 4'd1;
                        end
                        if (ftype != T_RD) begin
                            shreg <= {shreg[FRAME_W-2:0], mosi};
                        end else begin
                            // Only the 4 address bits are kept.
                            if (bitcnt < CNT_ADDR) begin
                                shreg <= {shreg[FRAME_W-2:0], mosi};
                            end
                            if (bitcnt == CNT_ADDR) begin
                                outreg <= dcache_rdata_in;
                            end else if (bitcnt > CNT_ADDR) begin
                                outreg <= {outreg[6:0], 1'b0};
                            end
                        end
                    end
                end

                COMMIT: begin
                    state   <= IDLE;
                    cm_iwen <= 1'b0;
                    cm_dwen <= 1'b0;
                    cm_addr <= '0;
                    cm_data <= '0;
                end

                RUN: begin
                    if (!run_in) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        icache_wen_out   = cm_iwen;
        icache_addr_out  = cm_iwen ? cm_addr : 4'h0;
        icache_wdata_out = cm_iwen ? cm_data : 8'h00;

        if (state == RUN) begin
            dcache_wen_out   = proc_dwen_in;
            dcache_addr_out  = proc_daddr_in;
            dcache_wdata_out = proc_dwdata_in;
        end else begin
            dcache_wen_out   = cm_dwen;
            dcache_addr_out  = cm_dwen  ? cm_addr
                             : rd_phase ? shreg[3:0]
                             : 4'h0;
            dcache_wdata_out = cm_dwen ? cm_data : 8'h00;
        end
    end

    assign miso          = outreg[7];
    assign proc_en_out   = (state == RUN);
    assign busy_out      = (state == SHIFT) || (state == COMMIT);
    assign frame_err_out = frame_err;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed bench for mem_loader.
// Frame table plus hand sequences for reset, readback, abort and run.

module tb_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       csi_n = 1'b1;
    logic       csd_n = 1'b1;
    logic       mosi = 1'b0;
    logic       run_in = 1'b0;
    logic       proc_dwen_in = 1'b0;
    logic [3:0] proc_daddr_in = 4'h0;
    logic [7:0] proc_dwdata_in = 8'h00;
    logic [7:0] dcache_rdata_in;
    logic       icache_wen_out;
    logic [3:0] icache_addr_out;
    logic [7:0] icache_wdata_out;
    logic       dcache_wen_out;
    logic [3:0] dcache_addr_out;
    logic [7:0] dcache_wdata_out;
    logic       miso;
    logic       proc_en_out;
    logic       busy_out;
    logic       frame_err_out;

    mem_loader #(.FRAME_W(12)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .csi_n            (csi_n),
        .csd_n            (csd_n),
        .mosi             (mosi),
        .run_in           (run_in),
        .proc_dwen_in     (proc_dwen_in),
        .proc_daddr_in    (proc_daddr_in),
        .proc_dwdata_in   (proc_dwdata_in),
        .dcache_rdata_in  (dcache_rdata_in),
        .icache_wen_out   (icache_wen_out),
        .icache_addr_out  (icache_addr_out),
        .icache_wdata_out (icache_wdata_out),
        .dcache_wen_out   (dcache_wen_out),
        .dcache_addr_out  (dcache_addr_out),
        .dcache_wdata_out (dcache_wdata_out),
        .miso             (miso),
        .proc_en_out      (proc_en_out),
        .busy_out         (busy_out),
        .frame_err_out    (frame_err_out)
    );

    always #5 clk = ~clk;

    // External dcache model.
    logic [7:0] dmem [16];
    assign dcache_rdata_in = dmem[dcache_addr_out];
    always @(posedge clk) begin
        if (dcache_wen_out) dmem[dcache_addr_out] <= dcache_wdata_out;
    end

    // Loader write-pulse monitor.
    int         iw_cnt = 0;
    int         dw_cnt = 0;
    logic [3:0] last_iaddr = 4'h0;
    logic [7:0] last_idata = 8'h00;
    logic [3:0] last_daddr = 4'h0;
    logic [7:0] last_ddata = 8'h00;
    always @(negedge clk) begin
        if (icache_wen_out) begin
            iw_cnt++;
            last_iaddr = icache_addr_out;
            last_idata = icache_wdata_out;
        end
        if (dcache_wen_out && !proc_en_out) begin
            dw_cnt++;
            last_daddr = dcache_addr_out;
            last_ddata = dcache_wdata_out;
        end
    end

    int passed = 0;
    int total = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_frame(input logic ci, input logic cd,
                              input logic [11:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            csi_n = ci;
            csd_n = cd;
            mosi = (i < 12) ? word[11-i] : 1'b0;
            tick();
        end
        csi_n = 1'b1;
        csd_n = 1'b1;
        mosi = 1'b0;
    endtask

    typedef struct {
        logic       ci;
        logic       cd;
        int         nbits;
        logic [7:0] data;
        logic [3:0] addr;
        int         exp_iw;
        int         exp_dw;
        logic       exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int iw0;
        int dw0;
        logic [3:0] raddr;
        logic [7:0] rexp;

        tbl[0] = '{1'b0, 1'b1, 12, 8'hA5, 4'h3, 1, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 12, 8'h7E, 4'h9, 0, 1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 12, 8'h3C, 4'hF, 1, 0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 12, 8'hC3, 4'h0, 0, 1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 11, 8'h55, 4'h6, 0, 0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 13, 8'hAA, 4'h5, 0, 0, 1'b1};

        // Reset state.
        #12;
        chk("rst_iwen", icache_wen_out, 0);
        chk("rst_iaddr", icache_addr_out, 0);
        chk("rst_idata", icache_wdata_out, 0);
        chk("rst_dwen", dcache_wen_out, 0);
        chk("rst_daddr", dcache_addr_out, 0);
        chk("rst_ddata", dcache_wdata_out, 0);
        chk("rst_miso", miso, 0);
        chk("rst_proc_en", proc_en_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_err", frame_err_out, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a frame.
        iw0 = iw_cnt;
        send_frame(1'b0, 1'b1, 12'hA53, 5);
        chk("mid_busy_before", busy_out, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", busy_out, 0);
        chk("mid_iwen", icache_wen_out, 0);
        chk("mid_err", frame_err_out, 0);
        chk("mid_miso", miso, 0);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("mid_no_write", iw_cnt - iw0, 0);

        // Frame table.
        for (int r = 0; r < 6; r++) begin
            iw0 = iw_cnt;
            dw0 = dw_cnt;
            send_frame(tbl[r].ci, tbl[r].cd,
                       {tbl[r].data, tbl[r].addr}, tbl[r].nbits);
            repeat (3) tick();
            chk($sformatf("row%0d_iwen", r), iw_cnt - iw0, tbl[r].exp_iw);
            chk($sformatf("row%0d_dwen", r), dw_cnt - dw0, tbl[r].exp_dw);
            if (tbl[r].exp_iw == 1) begin
                chk($sformatf("row%0d_iaddr", r), last_iaddr, tbl[r].addr);
                chk($sformatf("row%0d_idata", r), last_idata, tbl[r].data);
            end
            if (tbl[r].exp_dw == 1) begin
                chk($sformatf("row%0d_daddr", r), last_daddr, tbl[r].addr);
                chk($sformatf("row%0d_ddata", r), last_ddata, tbl[r].data);
            end
            chk($sformatf("row%0d_err", r), frame_err_out, tbl[r].exp_err);
            chk($sformatf("row%0d_busy", r), busy_out, 0);
        end

        // Readback of addr 9 (written 0x7E above).
        do_reset();
        chk("rd_err_cleared", frame_err_out, 0);
        raddr = 4'h9;
        rexp = 8'h7E;
        csi_n = 1'b0;
        csd_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            mosi = (i <= 4) ? raddr[4-i] : 1'($urandom_range(0, 1));
            tick();
            if (i == 4) begin
                chk("rd_addr", dcache_addr_out, raddr);
                chk("rd_miso_pre", miso, 0);
            end
            if (i >= 5) chk($sformatf("rd_miso_e%0d", i), miso, rexp[12-i]);
            if (i == 8) chk("rd_busy", busy_out, 1);
        end
        csi_n = 1'b1;
        csd_n = 1'b1;
        tick();
        chk("rd_miso_end", miso, 0);
        chk("rd_busy_end", busy_out, 0);
        chk("rd_err", frame_err_out, 0);

        // Arbitration.
        run_in = 1'b1;
        tick();
        chk("run_proc_en", proc_en_out, 1);
        proc_dwen_in = 1'b1;
        proc_daddr_in = 4'h2;
        proc_dwdata_in = 8'h11;
        #1;
        chk("run_dwen", dcache_wen_out, 1);
        chk("run_daddr", dcache_addr_out, 4'h2);
        chk("run_ddata", dcache_wdata_out, 8'h11);
        iw0 = iw_cnt;
        csi_n = 1'b0;
        mosi = 1'b1;
        repeat (4) tick();
        chk("run_busy", busy_out, 0);
        repeat (10) tick();
        csi_n = 1'b1;
        mosi = 1'b0;
        repeat (2) tick();
        chk("run_no_iwrite", iw_cnt - iw0, 0);
        chk("run_still_en", proc_en_out, 1);
        run_in = 1'b0;
        tick();
        chk("stop_proc_en", proc_en_out, 0);
        chk("stop_dwen", dcache_wen_out, 0);
        chk("stop_daddr", dcache_addr_out, 0);
        chk("stop_ddata", dcache_wdata_out, 0);
        proc_dwen_in = 1'b0;
        proc_daddr_in = 4'h0;
        proc_dwdata_in = 8'h00;

        // Select switch aborts the frame.
        do_reset();
        chk("sw_err_before", frame_err_out, 0);
        iw0 = iw_cnt;
        dw0 = dw_cnt;
        send_frame(1'b0, 1'b1, 12'hA53, 5);
        csi_n = 1'b0;
        csd_n = 1'b0;
        mosi = 1'b1;
        tick();
        chk("sw_err", frame_err_out, 1);
        chk("sw_busy", busy_out, 0);
        csi_n = 1'b1;
        csd_n = 1'b1;
        mosi = 1'b0;
        repeat (3) tick();
        chk("sw_no_iwrite", iw_cnt - iw0, 0);
        chk("sw_no_dwrite", dw_cnt - dw0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
